// File: rtl/iram_controller.sv
`default_nettype none
// ============================================================================
//  Module   : iram_controller
//  Purpose  : Instruction-cache line refill engine. On a fetch miss it reads
//             one aligned line of LINE_WORDS words from the backing
//             instruction memory, in ascending address order, and hands each
//             word to the fetch side with a one-cycle word_ready pulse.
//  Ports    :
//     clk          in   rising-edge clock
//     nrst         in   synchronous active-low reset
//     i_miss       in   miss request, held until the line is delivered
//     iram_address in   miss byte address [PC_SIZE]
//     imem_word    out  refill word to the fetch side [MEM_WORD]
//     word_ready   out  imem_word valid this cycle (single-cycle pulse)
//     mem_re       out  backing memory read strobe
//     mem_addr     out  backing memory word address [MEM_ADDR_W]
//     mem_rdata    in   backing memory read data [MEM_WORD]
//     busy         out  refill in progress
//  Revision : 1.0  initial release
// ============================================================================
module iram_controller #(
   parameter int PC_SIZE     = 32,
   parameter int MEM_WORD    = 32,
   parameter int MEM_ADDR_W  = 10,
   parameter int LINE_WORDS  = 4,
   parameter int MEM_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  i_miss,
   input  logic [PC_SIZE-1:0]    iram_address,
   output logic [MEM_WORD-1:0]   imem_word,
   output logic                  word_ready,
   output logic                  mem_re,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   input  logic [MEM_WORD-1:0]   mem_rdata,
   output logic                  busy
);

   localparam int CNT_W = $clog2(LINE_WORDS);
   localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

   localparam logic [CNT_W-1:0]      LAST_WORD = CNT_W'(LINE_WORDS - 1);
   localparam logic [LAT_W-1:0]      LAST_WAIT = LAT_W'(MEM_LATENCY - 1);
   localparam logic [MEM_ADDR_W-1:0] LINE_MASK = MEM_ADDR_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_WAIT    = 3'd2,
      S_DELIVER = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [MEM_ADDR_W-1:0] base_q,  base_d;
   logic [CNT_W-1:0]      cnt_q,   cnt_d;
   logic [LAT_W-1:0]      lat_q,   lat_d;
   logic [MEM_WORD-1:0]   word_q,  word_d;

   // Word address of the miss; byte-offset bits and bits above the memory
   // range play no part in the refill.
   logic [MEM_ADDR_W-1:0] w_line_addr;
   logic                  w_unused_addr_bits;

   assign w_line_addr        = iram_address[MEM_ADDR_W+1:2];
   assign w_unused_addr_bits = ^{iram_address[PC_SIZE-1:MEM_ADDR_W+2], iram_address[1:0]};

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         cnt_q   <= '0;
         lat_q   <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
         word_q  <= word_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      cnt_d      = cnt_q;
      lat_d      = lat_q;
      word_d     = word_q;
      mem_re     = 1'b0;
      word_ready = 1'b0;
      busy       = 1'b1;

      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (i_miss) begin
               base_d  = w_line_addr & ~LINE_MASK;
               cnt_d   = '0;
               state_d = S_REQ;
            end
         end

         S_REQ: begin
            mem_re  = 1'b1;
            lat_d   = '0;
            state_d = i_miss ? S_WAIT : S_IDLE;
         end

         // Read data lands in the last WAIT cycle; an abort leaves imem_word
         // untouched so it keeps the previously captured word.
         S_WAIT: begin
            if (!i_miss) begin
               state_d = S_IDLE;
            end else if (lat_q == LAST_WAIT) begin
               word_d  = mem_rdata;
               state_d = S_DELIVER;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end

         // The pulse is suppressed when the requester has already withdrawn,
         // so an aborted word is never presented.
         S_DELIVER: begin
            if (!i_miss) begin
               state_d = S_IDLE;
            end else begin
               word_ready = 1'b1;
               cnt_d      = cnt_q + 1'b1;
               state_d    = (cnt_q == LAST_WORD) ? S_DONE : S_REQ;
            end
         end

         // Hold here until the miss is released so the same miss is not
         // refilled twice.
         S_DONE: begin
            if (!i_miss) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // The counter only fills the cleared low bits of the base, so the line
   // wraps inside its aligned block and never crosses it.
   assign mem_addr  = base_q | MEM_ADDR_W'(cnt_q);
   assign imem_word = word_q;

endmodule
`default_nettype wire

// File: tb/tb_iram_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_iram_controller
//  Purpose  : Scoreboard bench for iram_controller. Instance A uses default
//             parameters and is driven by directed and random misses with
//             aborts, a mid-refill reset and address changes after capture.
//             Instance B uses LINE_WORDS=8, MEM_LATENCY=1 at the top of the
//             memory. A latency-accurate memory model returns random garbage
//             outside the valid read-data cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_iram_controller;

   localparam int MLA = 2;
   localparam int LWA = 4;
   localparam int MLB = 1;
   localparam int LWB = 8;

   typedef struct {
      int          cyc;
      logic [31:0] val;
   } ev_t;

   logic        clk = 1'b0;
   logic        nrst;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   logic [31:0] mem [0:1023];

   // instance A
   logic        i_miss_a;
   logic [31:0] iram_address_a;
   logic [31:0] imem_word_a;
   logic        word_ready_a;
   logic        mem_re_a;
   logic [9:0]  mem_addr_a;
   logic [31:0] mem_rdata_a;
   logic        busy_a;

   // instance B
   logic        i_miss_b;
   logic [31:0] iram_address_b;
   logic [31:0] imem_word_b;
   logic        word_ready_b;
   logic        mem_re_b;
   logic [9:0]  mem_addr_b;
   logic [31:0] mem_rdata_b;
   logic        busy_b;

   ev_t exp_re[$];
   ev_t exp_wr[$];
   ev_t rdq_a[$];
   ev_t rdq_b[$];
   ev_t got_re_b[$];
   ev_t got_wr_b[$];
   logic [31:0] model_word;

   iram_controller #(
      .PC_SIZE(32), .MEM_WORD(32), .MEM_ADDR_W(10),
      .LINE_WORDS(LWA), .MEM_LATENCY(MLA)
   ) u_dut_a (
      .clk(clk), .nrst(nrst), .i_miss(i_miss_a), .iram_address(iram_address_a),
      .imem_word(imem_word_a), .word_ready(word_ready_a), .mem_re(mem_re_a),
      .mem_addr(mem_addr_a), .mem_rdata(mem_rdata_a), .busy(busy_a)
   );

   iram_controller #(
      .PC_SIZE(32), .MEM_WORD(32), .MEM_ADDR_W(10),
      .LINE_WORDS(LWB), .MEM_LATENCY(MLB)
   ) u_dut_b (
      .clk(clk), .nrst(nrst), .i_miss(i_miss_b), .iram_address(iram_address_b),
      .imem_word(imem_word_b), .word_ready(word_ready_b), .mem_re(mem_re_b),
      .mem_addr(mem_addr_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- backing memory model: data valid L cycles after mem_re
   initial forever begin
      @(negedge clk); #1;
      if (mem_re_a === 1'b1) rdq_a.push_back('{cyc + MLA, {22'd0, mem_addr_a}});
      if (mem_re_b === 1'b1) rdq_b.push_back('{cyc + MLB, {22'd0, mem_addr_b}});
   end

   initial begin
      mem_rdata_a = '0;
      mem_rdata_b = '0;
      forever begin
         @(posedge clk); #1;
         while (rdq_a.size() > 0 && rdq_a[0].cyc < cyc) void'(rdq_a.pop_front());
         while (rdq_b.size() > 0 && rdq_b[0].cyc < cyc) void'(rdq_b.pop_front());
         if (rdq_a.size() > 0 && rdq_a[0].cyc == cyc) begin
            ev_t e;
            e = rdq_a.pop_front();
            mem_rdata_a = mem[e.val[9:0]];
         end else begin
            mem_rdata_a = $urandom;
         end
         if (rdq_b.size() > 0 && rdq_b[0].cyc == cyc) begin
            ev_t e;
            e = rdq_b.pop_front();
            mem_rdata_b = mem[e.val[9:0]];
         end else begin
            mem_rdata_b = $urandom;
         end
      end
   end

   // ---------------- monitor / scoreboard for instance A
   initial begin
      logic prev_wr;
      prev_wr = 1'b0;
      forever begin
         @(negedge clk); #1;
         if (mem_re_a === 1'b1) begin
            if (exp_re.size() == 0) chk("unexpected_mem_re", mem_re_a, 1'b0);
            else begin
               ev_t e;
               e = exp_re.pop_front();
               chk("mem_re_cycle", cyc, e.cyc);
               chk("mem_addr", mem_addr_a, e.val);
            end
         end
         if (word_ready_a === 1'b1) begin
            chk("word_ready_back_to_back", prev_wr, 1'b0);
            if (exp_wr.size() == 0) chk("unexpected_word_ready", word_ready_a, 1'b0);
            else begin
               ev_t e;
               e = exp_wr.pop_front();
               chk("word_ready_cycle", cyc, e.cyc);
               chk("imem_word", imem_word_a, e.val);
            end
         end
         prev_wr = (word_ready_a === 1'b1);
      end
   end

   // ---------------- collector for instance B
   initial forever begin
      @(negedge clk); #1;
      if (mem_re_b === 1'b1)     got_re_b.push_back('{cyc, {22'd0, mem_addr_b}});
      if (word_ready_b === 1'b1) got_wr_b.push_back('{cyc, imem_word_b});
   end

   // One miss on instance A captured at cycle c0, with i_miss held through
   // cycle c0+hold-1 and low from cycle t=c0+hold. Expected activity follows
   // the refill timetable: word k is requested at c0+1+k*(L+2), captured at
   // the end of the cycle before its delivery, delivered L+1 cycles after the
   // request. A withdrawn miss still shows a request made in cycle t but no
   // delivery in cycle t.
   task automatic do_miss(input logic [31:0] addr, input int hold, input logic [31:0] new_addr);
      int          c0, t, per, rc, wc;
      int unsigned base;
      @(negedge clk);
      c0 = cyc;
      i_miss_a = 1'b1;
      iram_address_a = addr;
      per  = MLA + 2;
      base = (addr >> 2) & 32'h3FF & ~(LWA - 1);
      t    = c0 + hold;
      for (int k = 0; k < LWA; k++) begin
         rc = c0 + 1 + k * per;
         wc = rc + MLA + 1;
         if (rc <= t) exp_re.push_back('{rc, base + k});
         if (wc <  t) exp_wr.push_back('{wc, mem[base + k]});
         if (wc <= t) model_word = mem[base + k];
      end
      @(negedge clk);
      iram_address_a = new_addr;
      while (cyc < t) @(negedge clk);
      chk("busy_while_miss", busy_a, 1'b1);
      i_miss_a = 1'b0;
      @(negedge clk);
      chk("busy_after_release", busy_a, 1'b0);
      chk("imem_word_hold", imem_word_a, model_word);
   endtask

   task automatic reset_mid_deliver(input logic [31:0] addr);
      int          c0, per, wc1;
      int unsigned base;
      @(negedge clk);
      c0 = cyc;
      i_miss_a = 1'b1;
      iram_address_a = addr;
      per  = MLA + 2;
      base = (addr >> 2) & 32'h3FF & ~(LWA - 1);
      for (int k = 0; k < 2; k++) begin
         exp_re.push_back('{c0 + 1 + k * per, base + k});
         exp_wr.push_back('{c0 + 2 + MLA + k * per, mem[base + k]});
      end
      wc1 = c0 + 2 + MLA + per;
      while (cyc < wc1) @(negedge clk);
      nrst = 1'b0;
      @(negedge clk);
      chk("rst_imem_word", imem_word_a, 32'd0);
      chk("rst_word_ready", word_ready_a, 1'b0);
      chk("rst_mem_re", mem_re_a, 1'b0);
      chk("rst_mem_addr", mem_addr_a, 10'd0);
      chk("rst_busy", busy_a, 1'b0);
      nrst = 1'b1;
      i_miss_a = 1'b0;
      model_word = '0;
      repeat (12) @(negedge clk);
      chk("post_rst_idle", busy_a, 1'b0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      nrst = 1'b0;
      i_miss_a = 1'b0;
      iram_address_a = '0;
      i_miss_b = 1'b0;
      iram_address_b = '0;
      model_word = '0;
      repeat (3) @(negedge clk);
      chk("reset_imem_word", imem_word_a, 32'd0);
      chk("reset_word_ready", word_ready_a, 1'b0);
      chk("reset_mem_re", mem_re_a, 1'b0);
      chk("reset_mem_addr", mem_addr_a, 10'd0);
      chk("reset_busy", busy_a, 1'b0);
      nrst = 1'b1;
      repeat (2) @(negedge clk);

      // full line, held through DONE for five cycles
      do_miss(32'h0000_0048, 1 + LWA * (MLA + 2) + 5, 32'h0000_0048);
      // abort during the WAIT of the second word, then a fresh miss
      do_miss(32'h0000_0048, 1 + (MLA + 2) + 1, 32'h0000_0048);
      do_miss(32'h0000_0100, 1 + LWA * (MLA + 2) + 1, 32'h0000_0100);
      // address moves right after capture
      do_miss(32'h0000_0048, 1 + LWA * (MLA + 2) + 2, 32'h0000_0200);
      // reset during delivery of the second word
      reset_mid_deliver(32'h0000_0048);

      for (int n = 0; n < 16; n++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         do_miss($urandom, $urandom_range(1, 1 + LWA * (MLA + 2) + 4), $urandom);
      end
      repeat (4) @(negedge clk);
      chk("exp_re_drained", exp_re.size(), 0);
      chk("exp_wr_drained", exp_wr.size(), 0);

      // instance B: 8-word line at the top of memory, latency 1
      @(negedge clk);
      c0 = cyc;
      i_miss_b = 1'b1;
      iram_address_b = 32'h0000_0FFC;
      repeat (1 + LWB * (MLB + 2) + 6) @(negedge clk);
      chk("b_busy_in_done", busy_b, 1'b1);
      i_miss_b = 1'b0;
      @(negedge clk);
      chk("b_busy_after_release", busy_b, 1'b0);
      chk("b_re_count", got_re_b.size(), LWB);
      chk("b_wr_count", got_wr_b.size(), LWB);
      for (int k = 0; k < LWB; k++) begin
         if (k < got_re_b.size()) begin
            chk("b_mem_addr", got_re_b[k].val, 32'h3F8 + k);
            chk("b_mem_re_cycle", got_re_b[k].cyc, c0 + 1 + k * (MLB + 2));
         end
         if (k < got_wr_b.size()) begin
            chk("b_word_ready_cycle", got_wr_b[k].cyc, c0 + 3 + k * (MLB + 2));
            chk("b_imem_word", got_wr_b[k].val, mem[32'h3F8 + k]);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/iram_controller.md
IRAM_CONTROLLER -- requirements
Module: iram_controller

Interface
REQ-001 SHALL have parameter PC_SIZE, default 32, width of the fetch miss byte address.
REQ-002 SHALL have parameter MEM_WORD, default 32, width of one instruction memory word.
REQ-003 SHALL have parameter MEM_ADDR_W, default 10, word-address width of the backing instruction memory.
REQ-004 SHALL have parameter LINE_WORDS, default 4, words per refill line (power of two, >=2).
REQ-005 SHALL have parameter MEM_LATENCY, default 2, backing memory read latency in cycles (>=1).
REQ-006 SHALL have ports, in this order:
- clk  in  1  clock, rising edge.
- nrst  in  1  reset: synchronous, active-low.
- i_miss  in  1  fetch-side cache miss request, level, held until the line is delivered.
- iram_address  in  PC_SIZE  miss byte address.
- imem_word  out  MEM_WORD  refill word to the fetch side.
- word_ready  out  1  one-cycle pulse; imem_word is valid this cycle.
- mem_re  out  1  backing memory read strobe.
- mem_addr  out  MEM_ADDR_W  backing memory word address.
- mem_rdata  in  MEM_WORD  backing memory read data.
- busy  out  1  refill in progress.

Function
REQ-007 SHALL implement states IDLE, REQ, WAIT, DELIVER, DONE; busy=1 in every state except IDLE.
REQ-008 IDLE: when i_miss=1 is sampled, SHALL capture line base = iram_address[MEM_ADDR_W+1:2] with its low log2(LINE_WORDS) bits cleared, clear word counter cnt, and go to REQ; iram_address bits outside this field are ignored.
REQ-009 REQ: SHALL drive mem_re=1 and mem_addr=base+cnt for exactly one cycle, then go to WAIT; mem_re=0 in all other states.
REQ-010 mem_rdata is valid in the cycle MEM_LATENCY cycles after the mem_re cycle; WAIT SHALL last exactly MEM_LATENCY cycles and SHALL register mem_rdata into imem_word at the end of its last cycle.
REQ-011 DELIVER: SHALL drive word_ready=1 for exactly one cycle and increment cnt; then go to REQ if cnt < LINE_WORDS-1 before the increment, otherwise go to DONE.
REQ-012 Words SHALL be delivered in ascending address order from the line base (no critical-word-first); the per-word period is MEM_LATENCY+2 cycles.
REQ-013 imem_word SHALL hold its last captured value between word_ready pulses and after the refill.
REQ-014 DONE: SHALL stay in DONE while i_miss=1 (no second refill of the same miss), and go to IDLE on the first cycle i_miss=0 is sampled.
REQ-015 If i_miss=0 is sampled in REQ, WAIT or DELIVER, SHALL abort to IDLE next cycle; the aborted word SHALL NOT pulse word_ready, and the in-flight read is discarded.
REQ-016 iram_address changes after capture SHALL be ignored until IDLE is re-entered.
REQ-017 mem_addr SHALL be base+cnt modulo 2^MEM_ADDR_W; a line SHALL NOT cross its aligned boundary.
REQ-018 word_ready SHALL never be high for two consecutive cycles.

Reset
REQ-019 On nrst=0 at a clock edge, the next state SHALL be IDLE, with cnt=0, base=0, imem_word=0, word_ready=0, mem_re=0, mem_addr=0, busy=0.
REQ-020 Reset asserted mid-refill SHALL discard the refill; no word_ready pulse SHALL occur until a new miss is sampled after reset release.

Verification
REQ-021 Defaults: i_miss=1 with iram_address=0x0000_0048 sampled in IDLE at cycle 0 -> mem_addr sequence 0x010,0x011,0x012,0x013; mem_re pulses at cycles 1,5,9,13; word_ready pulses at cycles 4,8,12,16, carrying the memory contents of those addresses; DONE at cycle 17.
REQ-022 i_miss held high through DONE for 5 cycles, then dropped -> no additional mem_re; busy falls the cycle after i_miss=0 is sampled.
REQ-023 i_miss dropped during the WAIT of word 2 -> IDLE next cycle; exactly 1 word_ready pulse seen; a new miss at 0x0000_0100 then fetches 0x040..0x043.
REQ-024 nrst=0 during the DELIVER of word 1 -> all outputs 0 the next cycle; no further word_ready until a new miss.
REQ-025 MEM_LATENCY=1, LINE_WORDS=8, iram_address=0x0000_0FFC -> base 0x3F8, mem_addr 0x3F8..0x3FF; word_ready every 3 cycles; mem_addr never reaches 0x000.
REQ-026 iram_address changed from 0x48 to 0x200 one cycle after capture -> refill still fetches 0x010..0x013.
